memory_responder: RTL and testbench

//  Memory-side responder for the datapath's MAR/MDR interface. Accepts read/write

---
 rtl/memory_responder_if.sv | 23 ++
 rtl/memory_responder.sv | 136 +++++++++++++
 tb/tb_memory_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/memory_responder_if.sv
// Request/response bundle between the control unit (MAR/MDR side) and the memory responder.
interface memory_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  read;
    logic                  write;
    logic [31:0]           address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] Mdatain;
    logic                  done;
    logic                  busy;
    logic                  err;

    modport master (
        output read, write, address, data_in,
        input  Mdatain, done, busy, err
    );

    modport slave (
        input  read, write, address, data_in,
        output Mdatain, done, busy, err
    );
endinterface

// File: rtl/memory_responder.sv
// Synchronous-RAM memory responder with programmable wait states, a 4-phase
// request/done handshake and rejection of out-of-range or conflicting requests.
module memory_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic               clock,
    input  logic               clear,
    memory_responder_if.slave  bus
);
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_op_write;
    logic                  w_latch;
    logic                  r_err;
    logic                  w_err_next;
    logic                  r_done;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_mdatain;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_any_req;
    logic w_bad_req;

    assign w_any_req = bus.read | bus.write;
    // A request is rejected if both strobes are high or it addresses beyond the array.
    assign w_bad_req = (bus.read & bus.write) | (|bus.address[31:ADDR_BITS]);

    // Next-state, counter, error flag and request-latch decisions.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_err_next   = r_err;
        w_latch      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req && w_bad_req) begin
                    w_err_next   = 1'b1;
                    w_state_next = S_DONE;
                end else if (w_any_req) begin
                    w_latch      = 1'b1;
                    w_cnt_next   = CNT_W'(WAIT_STATES);
                    w_state_next = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                if (r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    w_state_next = S_ACCESS;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_ACCESS: begin
                w_err_next   = 1'b0;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                if (!w_any_req) begin
                    w_err_next   = 1'b0;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_err_next   = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, latched request, status flags and read-data register.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state    <= S_IDLE;
            r_cnt      <= {CNT_W{1'b0}};
            r_addr     <= {ADDR_BITS{1'b0}};
            r_wdata    <= {DATA_WIDTH{1'b0}};
            r_op_write <= 1'b0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_mdatain  <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
            r_done  <= (w_state_next == S_DONE);
            r_busy  <= (w_state_next != S_IDLE);
            if (w_latch) begin
                r_addr     <= bus.address[ADDR_BITS-1:0];
                r_wdata    <= bus.data_in;
                r_op_write <= bus.write;
            end else begin
                r_addr     <= r_addr;
                r_wdata    <= r_wdata;
                r_op_write <= r_op_write;
            end
            if ((r_state == S_ACCESS) && !r_op_write) begin
                r_mdatain <= r_mem[r_addr];
            end else begin
                r_mdatain <= r_mdatain;
            end
        end
    end

    // Array is not reset; a reset during WAIT returns to IDLE so the write never lands.
    always_ff @(posedge clock) begin
        if ((r_state == S_ACCESS) && r_op_write) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign bus.Mdatain = r_mdatain;
    assign bus.done    = r_done;
    assign bus.busy    = r_busy;
    assign bus.err     = r_err;
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: one responder with two wait states and one with none, sharing clock and reset.
module tb_memory_responder;
    logic clock;
    logic clear;
    int   total;
    int   bad;

    memory_responder_if #(.DATA_WIDTH(32)) a_if ();
    memory_responder_if #(.DATA_WIDTH(32)) b_if ();

    memory_responder #(.DATA_WIDTH(32), .ADDR_BITS(9), .WAIT_STATES(2)) dut_w2 (
        .clock (clock),
        .clear (clear),
        .bus   (a_if.slave)
    );

    memory_responder #(.DATA_WIDTH(32), .ADDR_BITS(9), .WAIT_STATES(0)) dut_w0 (
        .clock (clock),
        .clear (clear),
        .bus   (b_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit sel, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] data);
        if (sel) begin
            b_if.read = rd; b_if.write = wr; b_if.address = addr; b_if.data_in = data;
        end else begin
            a_if.read = rd; a_if.write = wr; a_if.address = addr; a_if.data_in = data;
        end
    endtask

    function automatic logic [3:0] flags(input bit sel);
        if (sel) return {b_if.busy, b_if.done, b_if.err, 1'b0};
        else     return {a_if.busy, a_if.done, a_if.err, 1'b0};
    endfunction

    function automatic logic [31:0] rdata(input bit sel);
        if (sel) return b_if.Mdatain;
        else     return a_if.Mdatain;
    endfunction

    // Flags are packed as {busy, done, err, 0}.
    task automatic txn(input bit sel, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input int edges, input bit exp_err,
                       input string tag);
        drive(sel, rd, wr, addr, data);
        for (int i = 1; i <= edges; i++) begin
            step();
            if (i < edges) check({tag, "_wait"}, {28'd0, flags(sel)}, 32'h0000_0008);
        end
        check({tag, "_done"}, {28'd0, flags(sel)}, exp_err ? 32'h0000_000E : 32'h0000_000C);
        drive(sel, 1'b0, 1'b0, addr, data);
        step();
        check({tag, "_idle"}, {28'd0, flags(sel)}, 32'h0000_0000);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        step();
        check("rst_flags_a", {28'd0, flags(1'b0)}, 32'd0);
        check("rst_data_a",  rdata(1'b0), 32'd0);
        check("rst_flags_b", {28'd0, flags(1'b1)}, 32'd0);
        clear = 1'b1;
        step();

        // Known content at address 0 to detect aliasing of out-of-range writes.
        txn(1'b0, 1'b0, 1'b1, 32'd0, 32'hA5A5_0000, 4, 1'b0, "wr0");
        txn(1'b0, 1'b0, 1'b1, 32'd5, 32'h1234_ABCD, 4, 1'b0, "wr5");
        txn(1'b0, 1'b1, 1'b0, 32'd5, 32'h0, 4, 1'b0, "rd5");
        check("rd5_data", rdata(1'b0), 32'h1234_ABCD);

        txn(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 1, 1'b1, "oob");
        check("oob_data", rdata(1'b0), 32'h1234_ABCD);
        txn(1'b0, 1'b1, 1'b0, 32'd0, 32'h0, 4, 1'b0, "rd0");
        check("rd0_data", rdata(1'b0), 32'hA5A5_0000);

        txn(1'b0, 1'b1, 1'b1, 32'd5, 32'h0, 1, 1'b1, "both");
        check("both_data", rdata(1'b0), 32'hA5A5_0000);
        txn(1'b0, 1'b1, 1'b0, 32'd5, 32'h0, 4, 1'b0, "rd5b");
        check("rd5b_data", rdata(1'b0), 32'h1234_ABCD);

        // Hold read high well past done.
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'h0);
        for (int i = 0; i < 4; i++) step();
        check("hold_done", {28'd0, flags(1'b0)}, 32'h0000_000C);
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_flags", {28'd0, flags(1'b0)}, 32'h0000_000C);
            check("hold_data", rdata(1'b0), 32'hA5A5_0000);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
        step();
        check("hold_release", {28'd0, flags(1'b0)}, 32'd0);

        // Reset in the middle of a write's wait period.
        txn(1'b0, 1'b0, 1'b1, 32'd7, 32'h0000_0011, 4, 1'b0, "wr7");
        drive(1'b0, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFF);
        step();
        check("abort_busy", {28'd0, flags(1'b0)}, 32'h0000_0008);
        drive(1'b0, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFF);
        clear = 1'b0;
        #1;
        check("abort_flags", {28'd0, flags(1'b0)}, 32'd0);
        check("abort_data",  rdata(1'b0), 32'd0);
        step();
        clear = 1'b1;
        step();
        txn(1'b0, 1'b1, 1'b0, 32'd7, 32'h0, 4, 1'b0, "rd7");
        check("rd7_data", rdata(1'b0), 32'h0000_0011);

        // Zero wait states.
        txn(1'b1, 1'b0, 1'b1, 32'd1, 32'hCAFE_0001, 2, 1'b0, "z_wr1");
        txn(1'b1, 1'b0, 1'b1, 32'd2, 32'h0BAD_F00D, 2, 1'b0, "z_wr2");
        txn(1'b1, 1'b1, 1'b0, 32'd1, 32'h0, 2, 1'b0, "z_rd1");
        check("z_rd1_data", rdata(1'b1), 32'hCAFE_0001);
        txn(1'b1, 1'b1, 1'b0, 32'd2, 32'h0, 2, 1'b0, "z_rd2");
        check("z_rd2_data", rdata(1'b1), 32'h0BAD_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
